// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall control for the EX-stage operand muxes.
// Optional event counters are compiled in when FWD_STATS_EN is defined.
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  input  logic                  freeze,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  stall
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]           stall_count,
  output logic [31:0]           fwd_count
`endif
);

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  logic [REG_ADDR_W-1:0] ex_rs_reg, ex_rt_reg, ex_dst_reg;
  logic                  ex_rw_reg, ex_mr_reg;
  logic [REG_ADDR_W-1:0] ex_rs_next, ex_rt_next, ex_dst_next;
  logic                  ex_rw_next, ex_mr_next;

  // The load flag leaves the tracking state after EX: once a load reaches
  // MEM its result is forwardable like any ALU result, so nothing downstream
  // needs to know it was a load.
  logic [REG_ADDR_W-1:0] mem_dst_reg, wb_dst_reg;
  logic                  mem_rw_reg, wb_rw_reg;

  logic bubble_in;

  assign stall = ~flush & ex_mr_reg & ex_rw_reg & (ex_dst_reg != REG_ZERO) &
                 ((ex_dst_reg == id_rs) | (ex_dst_reg == id_rt));

  assign bubble_in = flush | stall;

  always_comb begin
    ex_rs_next  = id_rs;
    ex_rt_next  = id_rt;
    ex_dst_next = id_dst;
    ex_rw_next  = id_reg_write;
    ex_mr_next  = id_mem_read;
    if (bubble_in) begin
      ex_rs_next  = REG_ZERO;
      ex_rt_next  = REG_ZERO;
      ex_dst_next = REG_ZERO;
      ex_rw_next  = 1'b0;
      ex_mr_next  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_rs_reg   <= REG_ZERO;
      ex_rt_reg   <= REG_ZERO;
      ex_dst_reg  <= REG_ZERO;
      ex_rw_reg   <= 1'b0;
      ex_mr_reg   <= 1'b0;
      mem_dst_reg <= REG_ZERO;
      mem_rw_reg  <= 1'b0;
      wb_dst_reg  <= REG_ZERO;
      wb_rw_reg   <= 1'b0;
    end else if (!freeze) begin
      ex_rs_reg   <= ex_rs_next;
      ex_rt_reg   <= ex_rt_next;
      ex_dst_reg  <= ex_dst_next;
      ex_rw_reg   <= ex_rw_next;
      ex_mr_reg   <= ex_mr_next;
      mem_dst_reg <= ex_dst_reg;
      mem_rw_reg  <= ex_rw_reg;
      wb_dst_reg  <= mem_dst_reg;
      wb_rw_reg   <= mem_rw_reg;
    end
  end

  // Index 0 resolves operand A (rs), index 1 operand B (rt).
  logic [REG_ADDR_W-1:0] ex_src [2];
  logic [1:0]            fwd_sel [2];

  assign ex_src[0] = ex_rs_reg;
  assign ex_src[1] = ex_rt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic hit_mem;
      logic hit_wb;
      // A zero destination never matches, so source $0 can never forward.
      assign hit_mem = mem_rw_reg & (mem_dst_reg != REG_ZERO) & (mem_dst_reg == ex_src[gi]);
      assign hit_wb  = wb_rw_reg  & (wb_dst_reg  != REG_ZERO) & (wb_dst_reg  == ex_src[gi]);
      assign fwd_sel[gi] = hit_mem ? 2'b10 : (hit_wb ? 2'b01 : 2'b00);
    end
  endgenerate

  assign forward_a = fwd_sel[0];
  assign forward_b = fwd_sel[1];

`ifdef FWD_STATS_EN
  logic [31:0] stall_count_reg, fwd_count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count_reg <= '0;
      fwd_count_reg   <= '0;
    end else if (!freeze) begin
      if (stall)
        stall_count_reg <= stall_count_reg + 32'd1;
      if ((forward_a != 2'b00) || (forward_b != 2'b00))
        fwd_count_reg <= fwd_count_reg + 32'd1;
    end
  end

  assign stall_count = stall_count_reg;
  assign fwd_count   = fwd_count_reg;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed vector bench for fwd_hazard_ctrl; counter checks are active when
// FWD_STATS_EN is defined.
module tb_fwd_hazard_ctrl;

  localparam int W = 5;

  typedef struct {
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [W-1:0] dst;
    logic         rw;
    logic         mr;
    logic         fl;
    logic         fz;
    logic         rn;
    logic [1:0]   fa;
    logic [1:0]   fb;
    logic         st;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] id_rs, id_rt, id_dst;
  logic         id_reg_write, id_mem_read;
  logic         flush, freeze;
  logic [1:0]   forward_a, forward_b;
  logic         stall;
`ifdef FWD_STATS_EN
  logic [31:0]  stall_count, fwd_count;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  int stall_seen = 0;
  int exp_sc = 0;
  int exp_fc = 0;

  vec_t vecs[$];

  fwd_hazard_ctrl #(.REG_ADDR_W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_dst       (id_dst),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .freeze       (freeze),
    .forward_a    (forward_a),
    .forward_b    (forward_b),
    .stall        (stall)
`ifdef FWD_STATS_EN
    ,
    .stall_count  (stall_count),
    .fwd_count    (fwd_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int rs, input int rt, input int dst,
                              input int rw, input int mr, input int fl,
                              input int fz, input int rn, input int fa,
                              input int fb, input int st);
    vec_t v;
    v.rs = rs[W-1:0];  v.rt = rt[W-1:0];  v.dst = dst[W-1:0];
    v.rw = rw[0];      v.mr = mr[0];      v.fl = fl[0];
    v.fz = fz[0];      v.rn = rn[0];
    v.fa = fa[1:0];    v.fb = fb[1:0];    v.st = st[0];
    return v;
  endfunction

  function automatic vec_t idle(input int fa, input int fb);
    return mk(0, 0, 0, 0, 0, 0, 0, 1, fa, fb, 0);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    else
      pass_cnt++;
  endtask

  // Drive one ID-stage cycle, check outputs before the next rising edge,
  // then advance the counter model for the edge that follows.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    id_rs = v.rs; id_rt = v.rt; id_dst = v.dst;
    id_reg_write = v.rw; id_mem_read = v.mr;
    flush = v.fl; freeze = v.fz; rst_n = v.rn;
    #1;
    $display("vec %0d: rs=%0d rt=%0d dst=%0d rw=%0b mr=%0b fl=%0b fz=%0b rn=%0b -> fa=%b fb=%b st=%0b",
             idx, v.rs, v.rt, v.dst, v.rw, v.mr, v.fl, v.fz, v.rn, forward_a, forward_b, stall);
    chk("forward_a", idx, {30'd0, forward_a}, {30'd0, v.fa});
    chk("forward_b", idx, {30'd0, forward_b}, {30'd0, v.fb});
    chk("stall", idx, {31'd0, stall}, {31'd0, v.st});
    if (stall) stall_seen++;
`ifdef FWD_STATS_EN
    chk("stall_count", idx, stall_count, exp_sc);
    chk("fwd_count", idx, fwd_count, exp_fc);
`endif
    if (!v.rn) begin
      exp_sc = 0;
      exp_fc = 0;
    end else if (!v.fz) begin
      if (v.st) exp_sc++;
      if (v.fa != 2'b00 || v.fb != 2'b00) exp_fc++;
    end
  endtask

  initial begin
    rst_n = 1'b0; id_rs = '0; id_rt = '0; id_dst = '0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; flush = 1'b0; freeze = 1'b0;
    repeat (2) @(posedge clk);

    // reset state and idle
    vecs.push_back(idle(0, 0));
    vecs.push_back(idle(0, 0));
    // add $3 ; sub rs=$3 -> EX/MEM forward
    vecs.push_back(mk(1, 2, 3, 1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(3, 6, 8, 1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(idle(2, 0));
    vecs.push_back(idle(0, 0));
    vecs.push_back(idle(0, 0));
    // one independent instruction between -> MEM/WB forward
    vecs.push_back(mk(1, 2, 3, 1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(10, 11, 12, 1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(3, 6, 8, 1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(idle(1, 0));
    vecs.push_back(idle(0, 0));
    vecs.push_back(idle(0, 0));
    // two independent instructions between -> regfile
    vecs.push_back(mk(1, 2, 3, 1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(10, 11, 12, 1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(13, 14, 15, 1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(3, 6, 8, 1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(idle(0, 0));
    vecs.push_back(idle(0, 0));
    vecs.push_back(idle(0, 0));
    // double hazard on $5 -> most recent producer wins
    vecs.push_back(mk(1, 2, 5, 1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 2, 5, 1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(9, 5, 10, 1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(idle(0, 2));
    vecs.push_back(idle(0, 0));
    vecs.push_back(idle(0, 0));
    // producers write $0, consumer reads $0 -> no forwarding
    vecs.push_back(mk(1, 2, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 2, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 10, 1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(idle(0, 0));
    vecs.push_back(idle(0, 0));
    vecs.push_back(idle(0, 0));
    // lw $4 ; consumer rt=$4 -> one stall, bubble, then MEM/WB forward
    vecs.push_back(mk(1, 0, 4, 1, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(2, 4, 9, 1, 0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(2, 4, 9, 1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(idle(0, 1));
    vecs.push_back(idle(0, 0));
    vecs.push_back(idle(0, 0));
    // load-use with flush -> no stall, consumer squashed
    vecs.push_back(mk(1, 0, 4, 1, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(2, 4, 9, 1, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(idle(0, 0));
    vecs.push_back(idle(0, 0));
    vecs.push_back(idle(0, 0));
    // load-use under a 3-cycle freeze, bubble on first unfrozen edge
    vecs.push_back(mk(1, 0, 4, 1, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(2, 4, 9, 1, 0, 0, 1, 1, 0, 0, 1));
    vecs.push_back(mk(2, 4, 9, 1, 0, 0, 1, 1, 0, 0, 1));
    vecs.push_back(mk(2, 4, 9, 1, 0, 0, 1, 1, 0, 0, 1));
    vecs.push_back(mk(2, 4, 9, 1, 0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(2, 4, 9, 1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(idle(0, 1));
    vecs.push_back(idle(0, 0));
    vecs.push_back(idle(0, 0));
    // mid-stream reset discards the tracked producer/consumer
    vecs.push_back(mk(1, 2, 3, 1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(3, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(idle(0, 0));
    vecs.push_back(idle(0, 0));
    // reset wins over freeze
    vecs.push_back(mk(1, 2, 3, 1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(3, 0, 8, 1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0));
    vecs.push_back(idle(0, 0));
    vecs.push_back(idle(0, 0));

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], i);

    // Hand sequence: lw $4 then a consumer reading $4 through rs, held in ID
    // while stalled; exactly one stall cycle, then operand A from MEM/WB.
    stall_seen = 0;
    apply(mk(1, 0, 4, 1, 1, 0, 0, 1, 0, 0, 0), 100);
    apply(mk(4, 0, 7, 1, 0, 0, 0, 1, 0, 0, 1), 101);
    apply(mk(4, 0, 7, 1, 0, 0, 0, 1, 0, 0, 0), 102);
    apply(idle(1, 0), 103);
    apply(idle(0, 0), 104);
    chk("stall_cycles", 104, stall_seen, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
